multicycle_control_fsm: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath. Decodes opcode, sequences fetch/decode/execute/mem/writeback.

---
 rtl/multicycle_control_fsm_pkg.sv | 54 +++++
 rtl/multicycle_control_fsm.sv | 143 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// multicycle_control_fsm_pkg: opcodes, ALUOp codes and state encodings shared with the ALU control decoder
package multicycle_control_fsm_pkg;
  localparam int OP_W = 6;
  localparam int ALUOP_W = 5;
  localparam logic [OP_W-1:0] OP_R = 6'b000000;
  localparam logic [OP_W-1:0] OP_J = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW = 6'b101011;
  localparam logic [ALUOP_W-1:0] ALU_R = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_ADDI = 5'b00001;
  localparam logic [ALUOP_W-1:0] ALU_ANDI = 5'b00010;
  localparam logic [ALUOP_W-1:0] ALU_ORI = 5'b00011;
  localparam logic [ALUOP_W-1:0] ALU_LUI = 5'b00100;
  localparam logic [ALUOP_W-1:0] ALU_LW = 5'b00101;
  localparam logic [ALUOP_W-1:0] ALU_SW = 5'b00110;
  localparam logic [ALUOP_W-1:0] ALU_BEQ = 5'b00111;
  localparam logic [ALUOP_W-1:0] ALU_BNE = 5'b01001;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB,
    R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL_ST
  } stateT;
  function automatic logic [ALUOP_W-1:0] aluCode(input logic [OP_W-1:0] op);
    case (op)
      OP_ADDI: return ALU_ADDI;
      OP_ANDI: return ALU_ANDI;
      OP_ORI:  return ALU_ORI;
      OP_LUI:  return ALU_LUI;
      OP_LW:   return ALU_LW;
      OP_SW:   return ALU_SW;
      OP_BEQ:  return ALU_BEQ;
      OP_BNE:  return ALU_BNE;
      default: return ALU_R;
    endcase
  endfunction
  // Unknown opcodes route back to FETCH; the caller flags them as illegal
  function automatic stateT route(input logic [OP_W-1:0] op);
    case (op)
      OP_LW, OP_SW: return MEM_ADDR;
      OP_R: return R_EXEC;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return I_EXEC;
      OP_BEQ, OP_BNE: return BRANCH;
      OP_J: return JUMP;
      OP_JAL: return JAL_ST;
      default: return FETCH;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: main control FSM of the multicycle MIPS datapath
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               alu_regw,
  input  logic               alu_jump,
  input  logic               mem_ready,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done
);
  stateT state, nextState;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : nextState;
  // Handshake and JR qualifiers come straight from inputs so a stalled state holds its outputs
  always_comb begin
    nextState = IDLE;
    alu_op = '0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne = 1'b0;
    iord = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 2'd0;
    mem_to_reg = 2'd0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    pc_source = 2'd0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        mem_read = 1'b1;
        alu_src_b = 2'd1;
        alu_op = ALU_ADDI;
        ir_write = mem_ready;
        pc_write = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        alu_op = ALU_ADDI;
        nextState = route(opcode);
        illegal_op = nextState == FETCH;
        instr_done = nextState == FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op = aluCode(opcode);
        nextState = opcode == OP_SW ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        iord = 1'b1;
        mem_read = 1'b1;
        nextState = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WRITE: begin
        iord = 1'b1;
        mem_write = 1'b1;
        instr_done = mem_ready;
        nextState = mem_ready ? FETCH : MEM_WRITE;
      end
      MEM_WB: begin
        mem_to_reg = 2'd1;
        reg_write = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = ALU_R;
        pc_source = alu_jump ? 2'd3 : 2'd0;
        pc_write = alu_jump;
        instr_done = alu_jump;
        nextState = alu_jump ? FETCH : R_WB;
      end
      R_WB: begin
        reg_dst = 2'd1;
        reg_write = alu_regw;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op = aluCode(opcode);
        nextState = I_WB;
      end
      I_WB: begin
        alu_op = aluCode(opcode);
        reg_write = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = aluCode(opcode);
        pc_source = 2'd1;
        pc_write_cond = 1'b1;
        branch_ne = opcode == OP_BNE;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        pc_source = 2'd2;
        pc_write = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      JAL_ST: begin
        pc_source = 2'd2;
        pc_write = 1'b1;
        reg_dst = 2'd2;
        mem_to_reg = 2'd2;
        reg_write = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed checks of the multicycle control FSM
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [5:0] opcode = '0;
  logic alu_regw = 1'b0, alu_jump = 1'b0, mem_ready = 1'b0;
  logic [4:0] alu_op;
  logic pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic reg_write, alu_src_a, illegal_op, instr_done;
  logic [23:0] allOuts;
  int tests = 0, fails = 0, doneCnt, wrCnt, regwCnt;
  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_regw(alu_regw), .alu_jump(alu_jump),
    .mem_ready(mem_ready), .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .illegal_op(illegal_op), .instr_done(instr_done)
  );
  assign allOuts = {alu_op, pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, illegal_op, instr_done};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    go(); go();
    chk("rst_outs", allOuts, 0);
    reset = 1'b1;
    #1;
    chk("idle_outs", allOuts, 0);
    go();
    chk("fetch_rd", mem_read, 1);
    chk("fetch_aluop", alu_op, 5'b00001);
    chk("fetch_srcb", alu_src_b, 1);
    chk("fetch_stall_irw", ir_write, 0);
    chk("fetch_stall_pcw", pc_write, 0);
    go();
    chk("fetch_hold", mem_read, 1);
    // LW with memory always ready
    opcode = 6'b100011;
    mem_ready = 1'b1;
    #1;
    chk("fetch_irw", ir_write, 1);
    chk("fetch_pcw", pc_write, 1);
    doneCnt = instr_done;
    go();
    chk("dec_srcb", alu_src_b, 3);
    chk("dec_ill", illegal_op, 0);
    doneCnt += instr_done;
    go();
    chk("lw_addr_aluop", alu_op, 5'b00101);
    chk("lw_addr_src", {alu_src_a, alu_src_b}, 3'b110);
    doneCnt += instr_done;
    go();
    chk("lw_rd", {iord, mem_read}, 2'b11);
    doneCnt += instr_done;
    go();
    chk("lw_wb_regw", reg_write, 1);
    chk("lw_wb_m2r", mem_to_reg, 1);
    doneCnt += instr_done;
    chk("lw_done_cnt", doneCnt, 1);
    go();
    chk("lw_back_fetch", mem_read, 1);
    // SW stalled three cycles in MEM_WRITE
    opcode = 6'b101011;
    go(); go();
    chk("sw_addr_aluop", alu_op, 5'b00110);
    go();
    mem_ready = 1'b0;
    #1;
    wrCnt = 0;
    regwCnt = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall_done", instr_done, 0);
      wrCnt += mem_write;
      regwCnt += reg_write;
      go();
    end
    mem_ready = 1'b1;
    #1;
    chk("sw_done", instr_done, 1);
    chk("sw_iord", iord, 1);
    wrCnt += mem_write;
    regwCnt += reg_write;
    chk("sw_wr_cnt", wrCnt, 4);
    chk("sw_no_regw", regwCnt, 0);
    go();
    chk("sw_back_fetch", {mem_read, mem_write}, 2'b10);
    // R-type then JR
    opcode = 6'b000000;
    alu_regw = 1'b1;
    go(); go();
    chk("r_exec", {alu_op, alu_src_a, alu_src_b, pc_write}, {5'b00000, 1'b1, 2'd0, 1'b0});
    go();
    chk("r_wb", {reg_write, reg_dst, instr_done}, {1'b1, 2'd1, 1'b1});
    go();
    alu_jump = 1'b1;
    alu_regw = 1'b0;
    go(); go();
    chk("jr_exec", {pc_source, pc_write, instr_done}, {2'd3, 1'b1, 1'b1});
    go();
    chk("jr_no_wb", {mem_read, reg_write}, 2'b10);
    // BNE and JAL
    alu_jump = 1'b0;
    opcode = 6'b000101;
    go(); go();
    chk("bne_aluop", alu_op, 5'b01001);
    chk("bne_ctl", {pc_write_cond, branch_ne, pc_source, pc_write}, {1'b1, 1'b1, 2'd1, 1'b0});
    go();
    opcode = 6'b000011;
    go(); go();
    chk("jal_ctl", {reg_dst, mem_to_reg, pc_write, pc_source, reg_write}, {2'd2, 2'd2, 1'b1, 2'd2, 1'b1});
    go();
    // ORI through I_EXEC/I_WB
    opcode = 6'b001101;
    go(); go();
    chk("ori_exec", {alu_op, alu_src_a, alu_src_b}, {5'b00011, 1'b1, 2'd2});
    go();
    chk("ori_wb", {alu_op, reg_write, reg_dst, mem_to_reg}, {5'b00011, 1'b1, 2'd0, 2'd0});
    go();
    // Illegal opcode
    opcode = 6'b111111;
    go();
    chk("ill_pulse", {illegal_op, instr_done}, 2'b11);
    go();
    chk("ill_fetch", {mem_read, illegal_op}, 2'b10);
    // Reset during a stalled store
    opcode = 6'b101011;
    go(); go(); go();
    mem_ready = 1'b0;
    #1;
    chk("sw2_wr", mem_write, 1);
    reset = 1'b0;
    go();
    chk("abort_outs", allOuts, 0);
    reset = 1'b1;
    mem_ready = 1'b1;
    go();
    chk("abort_fetch", {mem_read, alu_op}, {1'b1, 5'b00001});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
